// File: rtl/period_to_freq.sv
// Converts an averaged period count (clk cycles) into a rounded frequency in Hz
// using a multi-cycle restoring divider: freq = floor((CLK_FREQ + floor(P/2)) / P).
module period_to_freq #(
  parameter int unsigned CLK_FREQ      = 200_000_000,
  parameter int unsigned COUNTER_WIDTH = 18,
  parameter int unsigned FREQ_WIDTH    = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic                     stable,
  output logic [FREQ_WIDTH-1:0]    freq,
  output logic                     freq_valid,
  output logic                     locked,
  output logic                     busy
);

  localparam int unsigned ITER_W = $clog2(FREQ_WIDTH + 1);
  localparam logic [FREQ_WIDTH-1:0] CLK_FREQ_W = FREQ_WIDTH'(CLK_FREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [COUNTER_WIDTH-1:0] p_latch;
  logic [COUNTER_WIDTH-1:0] last_period;
  logic [COUNTER_WIDTH-1:0] half_period;
  logic [FREQ_WIDTH-1:0]    dividend;
  logic [FREQ_WIDTH-1:0]    quotient;
  logic [FREQ_WIDTH:0]      remainder;
  logic [FREQ_WIDTH:0]      trial;
  logic [FREQ_WIDTH:0]      divisor_ext;
  logic [ITER_W-1:0]        iter;
  logic                     take;
  logic                     start;

  assign half_period = period >> 1;
  assign start = stable && (period != '0) && (period != last_period);

  // One restoring-division step: shift the next dividend bit into the remainder
  // and subtract the divisor whenever it fits.
  assign divisor_ext = (FREQ_WIDTH+1)'(p_latch);
  assign trial       = (remainder << 1) | {{FREQ_WIDTH{1'b0}}, dividend[FREQ_WIDTH-1]};
  assign take        = (trial >= divisor_ext);

  assign busy = (state == CALC) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (!stable) begin
          state_next = IDLE;
        end else if (iter == ITER_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and output registers; losing stable clears the lock in every
  // state and takes priority over the DONE update of locked/last_period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_latch     <= '0;
      last_period <= '0;
      dividend    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      iter        <= '0;
      freq        <= '0;
      freq_valid  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p_latch   <= period;
            dividend  <= CLK_FREQ_W + FREQ_WIDTH'(half_period);
            quotient  <= '0;
            remainder <= '0;
            iter      <= ITER_W'(FREQ_WIDTH);
          end
        end
        CALC: begin
          if (stable) begin
            remainder <= take ? (trial - divisor_ext) : trial;
            quotient  <= {quotient[FREQ_WIDTH-2:0], take};
            dividend  <= dividend << 1;
            iter      <= iter - ITER_W'(1);
          end
        end
        DONE: begin
          freq        <= quotient;
          freq_valid  <= 1'b1;
          last_period <= p_latch;
          locked      <= 1'b1;
        end
        default: begin
        end
      endcase
      if (!stable) begin
        locked      <= 1'b0;
        last_period <= '0;
      end
    end
  end

endmodule

// File: tb/tb_period_to_freq.sv
// Directed bench for period_to_freq: a transaction-level model checked every cycle,
// plus hand-computed literal results for the documented scenarios.
module tb_period_to_freq;

  localparam int unsigned CLK_FREQ      = 200_000_000;
  localparam int unsigned COUNTER_WIDTH = 18;
  localparam int unsigned FREQ_WIDTH    = 28;

  logic                     clk;
  logic                     rst_n;
  logic [COUNTER_WIDTH-1:0] period;
  logic                     stable;
  logic [FREQ_WIDTH-1:0]    freq;
  logic                     freq_valid;
  logic                     locked;
  logic                     busy;

  int compare_count  = 0;
  int mismatch_count = 0;
  int valid_pulses   = 0;

  // Model: a conversion occupies FREQ_WIDTH+1 busy cycles, then publishes the rounded quotient.
  int     busy_left = 0;
  longint m_p       = 0;
  longint m_last    = 0;
  longint m_freq    = 0;
  bit     m_valid   = 0;
  bit     m_locked  = 0;

  period_to_freq #(
    .CLK_FREQ     (CLK_FREQ),
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .FREQ_WIDTH   (FREQ_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .period    (period),
    .stable    (stable),
    .freq      (freq),
    .freq_valid(freq_valid),
    .locked    (locked),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compare_count++;
    if (actual != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic stable_v, input int period_v);
    @(negedge clk);
    rst_n  = rst_v;
    stable = stable_v;
    period = COUNTER_WIDTH'(period_v);
  endtask

  task automatic waitValid(input string name, input int max_cycles, output int busy_seen);
    int start_pulses;
    bit seen;
    start_pulses = valid_pulses;
    busy_seen = 0;
    seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (valid_pulses != start_pulses) begin
        seen = 1;
        break;
      end
      if (busy) busy_seen++;
    end
    if (!seen) begin
      compare_count++;
      mismatch_count++;
      $display("[TB] FAIL %s: no freq_valid within %0d cycles", name, max_cycles);
    end
  endtask

  // Model update from the inputs sampled at this edge, then compare DUT outputs 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy_left = 0;
      m_p = 0;
      m_last = 0;
      m_freq = 0;
      m_valid = 0;
      m_locked = 0;
    end else begin
      m_valid = 0;
      if (busy_left == 0) begin
        if (stable && period != 0 && longint'(period) != m_last) begin
          m_p = longint'(period);
          busy_left = FREQ_WIDTH + 1;
        end
      end else if (busy_left == 1) begin
        m_freq = (longint'(CLK_FREQ) + m_p / 2) / m_p;
        m_valid = 1;
        m_last = m_p;
        m_locked = 1;
        busy_left = 0;
      end else if (!stable) begin
        busy_left = 0;
      end else begin
        busy_left--;
      end
      if (!stable) begin
        m_locked = 0;
        m_last = 0;
      end
    end
    #1;
    if (freq_valid) valid_pulses++;
    checkOutput("model_freq", longint'(freq), m_freq);
    checkOutput("model_freq_valid", longint'(freq_valid), longint'(m_valid));
    checkOutput("model_locked", longint'(locked), longint'(m_locked));
    checkOutput("model_busy", longint'(busy), longint'(busy_left != 0));
  end

  initial begin
    int busy_cnt;
    int pulses_before;
    rst_n  = 1'b0;
    stable = 1'b0;
    period = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_freq", longint'(freq), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_locked", longint'(locked), 0);

    // Slowest typical input: 200000 cycles -> 1000 Hz, 29 busy cycles
    applyStimulus(1'b1, 1'b1, 200000);
    waitValid("valid_200000", 60, busy_cnt);
    checkOutput("freq_200000", longint'(freq), 1000);
    checkOutput("busy_cycles_200000", busy_cnt, 29);
    checkOutput("locked_200000", longint'(locked), 1);

    applyStimulus(1'b1, 1'b1, 2000);
    waitValid("valid_2000", 60, busy_cnt);
    checkOutput("freq_2000", longint'(freq), 100000);

    applyStimulus(1'b1, 1'b1, 7);
    waitValid("valid_7", 60, busy_cnt);
    checkOutput("freq_7_rounded_up", longint'(freq), 28571429);

    applyStimulus(1'b1, 1'b1, 1);
    waitValid("valid_1", 60, busy_cnt);
    checkOutput("freq_1", longint'(freq), 200000000);

    // Holding the same period must not retrigger
    pulses_before = valid_pulses;
    repeat (1000) @(negedge clk);
    checkOutput("no_retrigger_pulses", valid_pulses - pulses_before, 0);
    checkOutput("held_busy", longint'(busy), 0);

    applyStimulus(1'b1, 1'b0, 1);
    @(negedge clk);
    checkOutput("unlock_on_drop", longint'(locked), 0);
    applyStimulus(1'b1, 1'b1, 1);
    waitValid("valid_reassert", 60, busy_cnt);
    checkOutput("freq_reassert", longint'(freq), 200000000);
    checkOutput("locked_reassert", longint'(locked), 1);

    // Abort during CALC: freq keeps its previous value
    applyStimulus(1'b1, 1'b1, 2000);
    repeat (10) @(negedge clk);
    stable = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", longint'(busy), 0);
    checkOutput("abort_freq_held", longint'(freq), 200000000);
    checkOutput("abort_locked", longint'(locked), 0);
    pulses_before = valid_pulses;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_valid", valid_pulses - pulses_before, 0);

    // stable falls during DONE: result still publishes, lock clear wins
    applyStimulus(1'b1, 1'b1, 5);
    repeat (29) @(negedge clk);
    stable = 1'b0;
    @(negedge clk);
    checkOutput("done_drop_valid", longint'(freq_valid), 1);
    checkOutput("done_drop_freq", longint'(freq), 40000000);
    checkOutput("done_drop_locked", longint'(locked), 0);

    // Reset mid-CALC discards the conversion
    applyStimulus(1'b1, 1'b1, 200000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midcalc_reset_freq", longint'(freq), 0);
    checkOutput("midcalc_reset_busy", longint'(busy), 0);
    checkOutput("midcalc_reset_valid", longint'(freq_valid), 0);
    checkOutput("midcalc_reset_locked", longint'(locked), 0);

    rst_n = 1'b1;
    period = '0;
    pulses_before = valid_pulses;
    repeat (50) @(negedge clk);
    checkOutput("zero_period_busy", longint'(busy), 0);
    checkOutput("zero_period_locked", longint'(locked), 0);
    checkOutput("zero_period_no_valid", valid_pulses - pulses_before, 0);

    applyStimulus(1'b1, 1'b1, 3);
    waitValid("valid_3", 60, busy_cnt);
    checkOutput("freq_3", longint'(freq), 66666667);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/period_to_freq.md
PERIOD_TO_FREQ -- requirements
Module: period_to_freq

Interface
REQ-001 Parameter CLK_FREQ, default 200_000_000, SHALL set the sampling clock frequency in Hz used as the dividend.
REQ-002 Parameter COUNTER_WIDTH, default 18, SHALL set the width of the incoming period count.
REQ-003 Parameter FREQ_WIDTH, default 28, SHALL set the quotient width; CLK_FREQ + 2^(COUNTER_WIDTH-1) SHALL fit in FREQ_WIDTH bits.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-005 period  input  COUNTER_WIDTH  averaged period in clk cycles, from the upstream period detector.
REQ-006 stable  input  1  high while the upstream period value is valid and stable.
REQ-007 freq  output  FREQ_WIDTH  last computed frequency in Hz.
REQ-008 freq_valid  output  1  one-cycle pulse when freq updates.
REQ-009 locked  output  1  high while freq corresponds to the current stable period.
REQ-010 busy  output  1  high while a division is in progress.

Function
REQ-011 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-012 In IDLE, a conversion SHALL start when stable=1, period!=0 and period!=last_period: latch P=period, load dividend CLK_FREQ+(period>>1), clear the quotient, load an iteration counter with FREQ_WIDTH, and go to CALC.
REQ-013 CALC SHALL run a restoring division, one quotient bit per cycle MSB-first, for exactly FREQ_WIDTH cycles, then go to DONE.
REQ-014 The result SHALL equal floor((CLK_FREQ + floor(P/2)) / P), i.e. rounded to nearest.
REQ-015 In DONE, freq SHALL take the quotient, freq_valid SHALL be 1 for that cycle, last_period SHALL take P, locked SHALL be set, and the FSM SHALL return to IDLE next cycle.
REQ-016 Latency: if the start condition is sampled at edge k, freq and freq_valid SHALL update at edge k+FREQ_WIDTH+1.
REQ-017 busy SHALL be 1 exactly in CALC and DONE.
REQ-018 freq_valid SHALL be 0 in all states other than DONE.
REQ-019 Changes to period during CALC SHALL be ignored.
REQ-020 After DONE, IDLE SHALL re-evaluate REQ-012, so a changed period retriggers with no extra idle cycle beyond the single IDLE cycle.
REQ-021 If stable=0 in any cycle: in CALC the block SHALL abort to IDLE with no freq_valid and freq unchanged; in all states locked and last_period SHALL be cleared to 0.
REQ-022 freq SHALL hold its last value when stable drops; consumers qualify it with locked.
REQ-023 period=0 with stable=1 SHALL never start a conversion, and locked SHALL remain 0.
REQ-024 If stable deasserts in the same cycle the FSM is in DONE, the DONE updates SHALL complete except that locked and last_period SHALL end at 0 (clear wins).
REQ-025 Internal arithmetic SHALL use FREQ_WIDTH+1 bit partial remainders so no intermediate value wraps.

Reset
REQ-026 When rst_n=0 at a clk edge, the block SHALL enter IDLE and set freq=0, freq_valid=0, locked=0, busy=0 and last_period=0, the quotient and remainder to 0, and the counter to 0.
REQ-027 A reset during CALC SHALL discard the computation with no freq_valid pulse.
REQ-028 After reset, conversion SHALL restart from REQ-012 only when its conditions hold.

Verification
REQ-029 period=200000, stable=1 -> freq=1000, single freq_valid at edge k+29, busy high 29 cycles, locked=1.
REQ-030 Sequence period=2000 then period=7, stable held -> freq=100000 then freq=28571429 (rounded up), two freq_valid pulses; period=1 -> freq=200000000.
REQ-031 Same period held for 1000 cycles after DONE -> exactly one freq_valid, no retrigger; drop stable then reassert with same period -> locked clears, new conversion, freq_valid again.
REQ-032 stable dropped at CALC cycle 10 -> busy falls next cycle, no freq_valid, freq keeps previous value, locked=0.
REQ-033 rst_n=0 for one cycle mid-CALC -> all outputs 0 next edge; period=0 with stable=1 -> busy stays 0, locked stays 0.
